// File: rtl/pixel_packer.sv
// pixel_packer: assembles R/G/B colour-phase bytes into 24-bit pixels, tracks
// pixel/line position and generates registered hsync/vsync pulses.
module pixel_packer #(
  parameter int unsigned HSYNC_W = 4,
  parameter int unsigned VSYNC_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pix_in,
  input  logic        sel_r,
  input  logic        sel_g,
  input  logic        sel_b,
  input  logic        sel_blank,
  input  logic        sync_hb,
  input  logic        sync_vb,
  output logic [23:0] pix_rgb,
  output logic        pix_valid,
  output logic        blank_out,
  output logic        hsync,
  output logic        vsync,
  output logic [9:0]  px_cnt,
  output logic [9:0]  line_cnt,
  output logic        err_seq
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned PULSE_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1023);

  typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;

  phase_t             state, state_n;
  logic               blank_mode, blank_mode_n;
  logic [7:0]         r_q, g_q;
  logic [2:0]         nsel_c;
  logic               single_c, multi_c, sync_c, match_c;
  logic               latch_r_c, latch_g_c, emit_c, err_c;
  logic [PULSE_W-1:0] hs_cnt, vs_cnt;

  assign nsel_c   = 3'(sel_r) + 3'(sel_g) + 3'(sel_b) + 3'(sel_blank);
  assign single_c = (nsel_c == 3'd1);
  assign multi_c  = (nsel_c > 3'd1);
  assign sync_c   = sync_hb | sync_vb;

  // Phase state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PH_R;
      blank_mode <= 1'b0;
    end else begin
      state      <= state_n;
      blank_mode <= blank_mode_n;
    end
  end

  // Next phase, strobe matching and error detection; a sync overrides any
  // strobe except that a completing strobe still emits its pixel
  always_comb begin
    state_n      = state;
    blank_mode_n = blank_mode;
    latch_r_c    = 1'b0;
    latch_g_c    = 1'b0;
    emit_c       = 1'b0;
    err_c        = 1'b0;
    case (state)
      PH_R:    match_c = sel_r | sel_blank;
      PH_G:    match_c = blank_mode ? sel_blank : sel_g;
      default: match_c = blank_mode ? sel_blank : sel_b;
    endcase
    if (single_c && match_c && (state == PH_B)) begin
      emit_c = 1'b1;
    end
    if (sync_c) begin
      state_n = PH_R;
    end else if (multi_c || (single_c && !match_c)) begin
      err_c   = 1'b1;
      state_n = PH_R;
    end else if (single_c) begin
      case (state)
        PH_R: begin
          latch_r_c    = 1'b1;
          blank_mode_n = sel_blank;
          state_n      = PH_G;
        end
        PH_G: begin
          latch_g_c = 1'b1;
          state_n   = PH_B;
        end
        default: state_n = PH_R;
      endcase
    end
  end

  // Colour byte capture and pixel output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q       <= 8'h00;
      g_q       <= 8'h00;
      pix_rgb   <= 24'h0;
      pix_valid <= 1'b0;
      blank_out <= 1'b0;
      err_seq   <= 1'b0;
    end else begin
      if (latch_r_c) r_q <= pix_in;
      if (latch_g_c) g_q <= pix_in;
      pix_valid <= emit_c;
      blank_out <= emit_c & blank_mode;
      if (emit_c) pix_rgb <= blank_mode ? 24'h0 : {r_q, g_q, pix_in};
      if (err_c) err_seq <= 1'b1;
    end
  end

  // Pixel and line position counters; syncs take priority over increments
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_cnt   <= '0;
      line_cnt <= '0;
    end else begin
      if (sync_c)                          px_cnt <= '0;
      else if (emit_c && px_cnt != CNT_MAX) px_cnt <= px_cnt + CNT_W'(1);
      if (sync_vb)                            line_cnt <= '0;
      else if (sync_hb && line_cnt != CNT_MAX) line_cnt <= line_cnt + CNT_W'(1);
    end
  end

  // Sync pulse generators; a retrigger reloads the width counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_cnt <= '0;
      vs_cnt <= '0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
    end else begin
      hsync <= sync_hb | (hs_cnt > PULSE_W'(1));
      vsync <= sync_vb | (vs_cnt > PULSE_W'(1));
      if (sync_hb)                hs_cnt <= PULSE_W'(HSYNC_W);
      else if (hs_cnt != '0)      hs_cnt <= hs_cnt - PULSE_W'(1);
      if (sync_vb)                vs_cnt <= PULSE_W'(VSYNC_W);
      else if (vs_cnt != '0)      vs_cnt <= vs_cnt - PULSE_W'(1);
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: directed + randomized stimulus, reference model feeding a
// scoreboard queue, and a monitor that checks every cycle.
module tb_pixel_packer;
  localparam int HW = 4;
  localparam int VW = 2;
  localparam logic [3:0] S_R  = 4'b1000;
  localparam logic [3:0] S_G  = 4'b0100;
  localparam logic [3:0] S_B  = 4'b0010;
  localparam logic [3:0] S_BL = 4'b0001;
  localparam logic [3:0] S_0  = 4'b0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pix_in = 8'h00;
  logic        sel_r = 1'b0, sel_g = 1'b0, sel_b = 1'b0, sel_blank = 1'b0;
  logic        sync_hb = 1'b0, sync_vb = 1'b0;
  logic [23:0] pix_rgb;
  logic        pix_valid, blank_out, hsync, vsync, err_seq;
  logic [9:0]  px_cnt, line_cnt;

  always #5 clk = ~clk;

  pixel_packer #(.HSYNC_W(HW), .VSYNC_W(VW)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in),
    .sel_r(sel_r), .sel_g(sel_g), .sel_b(sel_b), .sel_blank(sel_blank),
    .sync_hb(sync_hb), .sync_vb(sync_vb),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid), .blank_out(blank_out),
    .hsync(hsync), .vsync(vsync), .px_cnt(px_cnt), .line_cnt(line_cnt),
    .err_seq(err_seq)
  );

  typedef struct {
    logic [23:0] rgb;
    logic        blank;
    logic [9:0]  px;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   errors  = 0;

  // Reference model: bytes collected so far for the pixel in progress
  int          m_phase;
  bit          m_blank;
  logic [7:0]  m_bytes [2];
  bit          m_err, m_valid;
  int          m_px, m_line, m_hs, m_vs;
  logic [23:0] m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_blank = 0; m_err = 0; m_valid = 0;
    m_px = 0; m_line = 0; m_hs = 0; m_vs = 0; m_last = 24'h0;
    m_bytes[0] = 8'h00; m_bytes[1] = 8'h00;
    sb_q.delete();
  endtask

  task automatic model_step(input logic [3:0] sel, input logic [7:0] pix, input bit hb, input bit vb);
    logic [3:0]  want;
    bit          ok, done;
    logic [23:0] pixel;
    exp_t        e;
    if (m_phase == 0) ok = (sel == S_R) || (sel == S_BL);
    else begin
      want = m_blank ? S_BL : ((m_phase == 1) ? S_G : S_B);
      ok   = (sel == want);
    end
    done  = (sel != S_0) && ok && (m_phase == 2);
    pixel = m_blank ? 24'h0 : {m_bytes[0], m_bytes[1], pix};
    if (hb || vb) m_phase = 0;
    else if (sel != S_0) begin
      if (!ok) begin
        m_err = 1; m_phase = 0;
      end else begin
        if (m_phase == 0) m_blank = (sel == S_BL);
        if (m_phase < 2) m_bytes[m_phase] = pix;
        m_phase = (m_phase + 1) % 3;
      end
    end
    if (hb || vb) m_px = 0;
    else if (done) m_px = (m_px < 1023) ? m_px + 1 : 1023;
    if (vb) m_line = 0;
    else if (hb) m_line = (m_line < 1023) ? m_line + 1 : 1023;
    m_hs = hb ? HW : ((m_hs > 0) ? m_hs - 1 : 0);
    m_vs = vb ? VW : ((m_vs > 0) ? m_vs - 1 : 0);
    m_valid = done;
    if (done) begin
      m_last  = pixel;
      e.rgb   = pixel;
      e.blank = m_blank;
      e.px    = 10'(m_px);
      sb_q.push_back(e);
    end
  endtask

  // Drive one cycle of inputs away from the rising edge and advance the model
  task automatic drive(input bit rst, input logic [3:0] sel, input logic [7:0] pix,
                       input bit hb, input bit vb);
    @(negedge clk);
    reset = rst;
    {sel_r, sel_g, sel_b, sel_blank} = sel;
    pix_in = pix; sync_hb = hb; sync_vb = vb;
    if (rst) model_reset();
    else model_step(sel, pix, hb, vb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, S_0, 8'($urandom), 0, 0);
  endtask

  task automatic pixel3(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    drive(0, s0, p0, 0, 0);
    drive(0, s1, p1, 0, 0);
    drive(0, s2, p2, 0, 0);
  endtask

  // Monitor: per-cycle checks and scoreboard pops on pix_valid
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("pix_valid", 32'(pix_valid), 32'(m_valid));
      if (pix_valid) begin
        if (sb_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_pixel: got %0h expected none at %0t", pix_rgb, $time);
        end else begin
          e = sb_q.pop_front();
          chk("pix_rgb", 32'(pix_rgb), 32'(e.rgb));
          chk("blank_out", 32'(blank_out), 32'(e.blank));
          chk("px_at_emit", 32'(px_cnt), 32'(e.px));
        end
      end else begin
        chk("pix_rgb_hold", 32'(pix_rgb), 32'(m_last));
        chk("blank_out_idle", 32'(blank_out), 32'(0));
      end
      chk("err_seq", 32'(err_seq), 32'(m_err));
      chk("px_cnt", 32'(px_cnt), 32'(m_px));
      chk("line_cnt", 32'(line_cnt), 32'(m_line));
      chk("hsync", 32'(hsync), 32'(m_hs > 0));
      chk("vsync", 32'(vsync), 32'(m_vs > 0));
    end
  end

  initial begin
    logic [3:0] s;
    int r;
    model_reset();
    repeat (3) drive(1, S_0, 8'h00, 0, 0);
    idle(2);

    // Colour pixel, then blank pixel
    pixel3(S_R, S_G, S_B, 8'h12, 8'h34, 8'h56);
    idle(2);
    pixel3(S_BL, S_BL, S_BL, 8'hFF, 8'hFF, 8'hFF);
    idle(2);

    // Sync mid-pixel discards without error; completing strobe with sync_hb
    drive(0, S_R, 8'hAA, 0, 0);
    drive(0, S_G, 8'hBB, 0, 0);
    drive(0, S_0, 8'h00, 1, 0);
    drive(0, S_R, 8'h01, 0, 0);
    drive(0, S_G, 8'h02, 0, 0);
    drive(0, S_B, 8'h03, 1, 0);
    idle(2);
    drive(0, S_BL, 8'h00, 0, 0);
    drive(0, S_0, 8'h00, 0, 1);
    idle(3);

    // Sequence error, then a good triplet
    drive(0, S_R, 8'h11, 0, 0);
    drive(0, S_B, 8'h22, 0, 0);
    idle(2);
    pixel3(S_R, S_G, S_B, 8'h9A, 8'hBC, 8'hDE);
    pixel3(S_R, S_BL, S_B, 8'h01, 8'h02, 8'h03);
    drive(0, S_R | S_G, 8'h04, 0, 0);
    idle(2);

    // 640-pixel line, then line start
    for (int i = 0; i < 640; i++)
      pixel3(S_R, S_G, S_B, 8'($urandom), 8'($urandom), 8'($urandom));
    drive(0, S_0, 8'h00, 1, 0);
    idle(6);

    // Retrigger of hsync
    drive(0, S_0, 8'h00, 1, 0);
    idle(2);
    drive(0, S_0, 8'h00, 1, 0);
    idle(6);

    // Lines up to 479, then simultaneous hb+vb
    while (m_line < 479) drive(0, S_0, 8'h00, 1, 0);
    idle(5);
    drive(0, S_0, 8'h00, 1, 1);
    idle(6);

    // px_cnt and line_cnt saturation
    for (int i = 0; i < 1030; i++) pixel3(S_BL, S_BL, S_BL, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 1030; i++) drive(0, S_0, 8'h00, 1, 0);
    drive(0, S_0, 8'h00, 0, 1);
    idle(5);

    // Reset mid-pixel, fresh triplet starting on the release cycle
    drive(0, S_R, 8'h77, 0, 0);
    drive(0, S_G, 8'h88, 0, 0);
    drive(1, S_0, 8'h00, 0, 0);
    drive(1, S_0, 8'h00, 0, 0);
    pixel3(S_R, S_G, S_B, 8'hC1, 8'hC2, 8'hC3);
    idle(2);
    drive(0, S_0, 8'h00, 1, 1);
    drive(1, S_0, 8'h00, 0, 0);
    pixel3(S_BL, S_BL, S_BL, 8'h55, 8'h66, 8'h77);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(99);
      if (r < 65) begin
        if (m_phase == 0) s = $urandom_range(1) ? S_R : S_BL;
        else s = m_blank ? S_BL : ((m_phase == 1) ? S_G : S_B);
      end else if (r < 80) s = S_0;
      else if (r < 92) s = 4'(1 << $urandom_range(3));
      else s = 4'($urandom_range(15));
      if ($urandom_range(999) < 3) drive(1, S_0, 8'h00, 0, 0);
      else drive(0, s, 8'($urandom), $urandom_range(99) < 3, $urandom_range(99) < 1);
    end
    idle(4);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
